pci_txn_queue: RTL and testbench

//  Upstream feeder for one PCI bus device: buffers host transaction descriptors (read/write, target

---
 rtl/pci_txn_queue_pkg.sv | 24 ++
 rtl/pci_txn_queue_if.sv | 49 ++++
 rtl/pci_txn_queue_cmd_fifo.sv | 54 +++++
 rtl/pci_txn_queue.sv | 142 ++++++++++++++
 tb/tb_pci_txn_queue.sv | 281 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pci_txn_queue_pkg.sv
// pci_txn_queue_pkg: shared definitions for the PCI transaction queue.
//   state_t       FSM state encoding (also exported on the debug port)
//   STATUS_*      completion status codes reported on done_status
//   DEF_ADDR_W/DEF_CNT_W  default address and word-count widths
package pci_txn_queue_pkg;

    localparam int DEF_ADDR_W = 32;
    localparam int DEF_CNT_W  = 4;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_REQ      = 3'd1,
        ST_WAIT_BUS = 3'd2,
        ST_START    = 3'd3,
        ST_BUSY     = 3'd4,
        ST_RETIRE   = 3'd5
    } state_t;

    localparam logic [1:0] STATUS_OK      = 2'b00;
    localparam logic [1:0] STATUS_ABORT   = 2'b01;
    localparam logic [1:0] STATUS_TIMEOUT = 2'b10;
    localparam logic [1:0] STATUS_ILLEGAL = 2'b11;

endpackage

// File: rtl/pci_txn_queue_if.sv
// pci_txn_queue_if: host command port, arbiter request/grant, observed bus
// signals, device command port and completion report of one queue instance.
//   slave  modport: the queue (pci_txn_queue)
//   master modport: host / arbiter / device side
// Handshake: a descriptor transfers on any rising clk where cmd_valid and
// cmd_ready are both 1; the host holds cmd_* stable while cmd_valid is 1 and
// cmd_ready is 0. request, grant, frame and i_ready are active-low.
interface pci_txn_queue_if
    import pci_txn_queue_pkg::*;
#(
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int CNT_W   = DEF_CNT_W,
    parameter int LEVEL_W = 3
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_cbe;
    logic [ADDR_W-1:0] cmd_addr;
    logic [CNT_W-1:0]  cmd_count;
    logic [LEVEL_W-1:0] level;
    logic              request;
    logic              grant;
    logic              frame;
    logic              i_ready;
    logic              dev_cbe;
    logic [ADDR_W-1:0] dev_addr;
    logic [CNT_W-1:0]  dev_count;
    logic              dev_start;
    logic              dev_done;
    logic              dev_abort;
    logic              done_valid;
    logic [1:0]        done_status;

    modport slave (
        input  cmd_valid, cmd_cbe, cmd_addr, cmd_count,
        input  grant, frame, i_ready, dev_done, dev_abort,
        output cmd_ready, level, request,
        output dev_cbe, dev_addr, dev_count, dev_start,
        output done_valid, done_status
    );

    modport master (
        output cmd_valid, cmd_cbe, cmd_addr, cmd_count,
        output grant, frame, i_ready, dev_done, dev_abort,
        input  cmd_ready, level, request,
        input  dev_cbe, dev_addr, dev_count, dev_start,
        input  done_valid, done_status
    );
endinterface

// File: rtl/pci_txn_queue_cmd_fifo.sv
// pci_cmd_fifo: synchronous descriptor FIFO, DEPTH entries of W bits.
//   clk, reset(async, active-low), push, pop, wdata -> rdata (head, combinational
//   from storage), level (occupancy), full, empty.
// Pushes while full and pops while empty are ignored. DEPTH must be a power
// of 2 so the pointers wrap by natural overflow.
module pci_cmd_fifo #(
    parameter int DEPTH   = 4,
    parameter int W       = 37,
    parameter int LEVEL_W = $clog2(DEPTH + 1)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               push,
    input  logic               pop,
    input  logic [W-1:0]       wdata,
    output logic [W-1:0]       rdata,
    output logic [LEVEL_W-1:0] level,
    output logic               full,
    output logic               empty
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (level == LEVEL_W'(DEPTH));
    assign empty   = (level == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (push_ok) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop_ok) rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   level <= level + LEVEL_W'(1);
                2'b01:   level <= level - LEVEL_W'(1);
                default: level <= level;
            endcase
        end
    end
endmodule

// File: rtl/pci_txn_queue.sv
// pci_txn_queue: buffers host descriptors, requests the PCI bus, starts the
// device on grant with an idle bus, and reports completion status.
//   clk, reset (async, active-low)
//   bus       pci_txn_queue_if.slave: cmd_*, level, request/grant, frame,
//             i_ready, dev_*, done_valid/done_status
//   dbg_state current FSM state
module pci_txn_queue
    import pci_txn_queue_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int CNT_W   = DEF_CNT_W,
    parameter int TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             reset,
    pci_txn_queue_if.slave   bus,
    output state_t           dbg_state
);
    localparam int LEVEL_W = $clog2(DEPTH + 1);
    localparam int ENTRY_W = 1 + ADDR_W + CNT_W;
    localparam int TIMER_W = $clog2(TIMEOUT + 1);

    state_t              state, state_n;
    logic [TIMER_W-1:0]  timer, timer_n;
    logic [1:0]          status_n;
    logic [ENTRY_W-1:0]  head;
    logic                head_cbe;
    logic [ADDR_W-1:0]   head_addr;
    logic [CNT_W-1:0]    head_count;
    logic [LEVEL_W-1:0]  fifo_level;
    logic                fifo_full;
    logic                fifo_empty;

    logic                request_q;
    logic                dev_start_q;
    logic                done_valid_q;
    logic [1:0]          done_status_q;
    logic                dev_cbe_q;
    logic [ADDR_W-1:0]   dev_addr_q;
    logic [CNT_W-1:0]    dev_count_q;

    pci_cmd_fifo #(.DEPTH(DEPTH), .W(ENTRY_W), .LEVEL_W(LEVEL_W)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (bus.cmd_valid),
        .pop   (state == ST_RETIRE),
        .wdata ({bus.cmd_cbe, bus.cmd_addr, bus.cmd_count}),
        .rdata (head),
        .level (fifo_level),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign {head_cbe, head_addr, head_count} = head;

    always_comb begin
        state_n  = state;
        timer_n  = '0;
        status_n = done_status_q;
        case (state)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    if (head_count == '0) begin
                        state_n  = ST_RETIRE;
                        status_n = STATUS_ILLEGAL;
                    end else begin
                        state_n = ST_REQ;
                    end
                end
            end
            ST_REQ: begin
                // Grant takes priority over an expiring timer.
                if (!bus.grant) begin
                    state_n = ST_WAIT_BUS;
                end else if (timer == TIMER_W'(TIMEOUT - 1)) begin
                    state_n  = ST_RETIRE;
                    status_n = STATUS_TIMEOUT;
                end else begin
                    timer_n = timer + 1'b1;
                end
            end
            ST_WAIT_BUS: begin
                if (bus.grant)                          state_n = ST_REQ;
                else if (bus.frame && bus.i_ready)      state_n = ST_START;
            end
            ST_START: state_n = ST_BUSY;
            ST_BUSY: begin
                if (bus.dev_abort) begin
                    state_n  = ST_RETIRE;
                    status_n = STATUS_ABORT;
                end else if (bus.dev_done) begin
                    state_n  = ST_RETIRE;
                    status_n = STATUS_OK;
                end
            end
            ST_RETIRE: state_n = ST_IDLE;
            default:   state_n = ST_IDLE;
        endcase
    end

    // Outputs are flopped from the next state so they line up with the state
    // register and go inactive as soon as reset asserts.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= ST_IDLE;
            timer         <= '0;
            request_q     <= 1'b1;
            dev_start_q   <= 1'b0;
            done_valid_q  <= 1'b0;
            done_status_q <= STATUS_OK;
            dev_cbe_q     <= 1'b0;
            dev_addr_q    <= '0;
            dev_count_q   <= '0;
        end else begin
            state         <= state_n;
            timer         <= timer_n;
            request_q     <= !(state_n inside {ST_REQ, ST_WAIT_BUS, ST_START});
            dev_start_q   <= (state_n == ST_START);
            done_valid_q  <= (state_n == ST_RETIRE);
            done_status_q <= status_n;
            // Head cannot change until the RETIRE pop, so these stay stable
            // from START through RETIRE.
            if (state_n != ST_IDLE) begin
                dev_cbe_q   <= head_cbe;
                dev_addr_q  <= head_addr;
                dev_count_q <= head_count;
            end
        end
    end

    assign bus.cmd_ready   = !fifo_full;
    assign bus.level       = fifo_level;
    assign bus.request     = request_q;
    assign bus.dev_start   = dev_start_q;
    assign bus.done_valid  = done_valid_q;
    assign bus.done_status = done_status_q;
    assign bus.dev_cbe     = dev_cbe_q;
    assign bus.dev_addr    = dev_addr_q;
    assign bus.dev_count   = dev_count_q;
    assign dbg_state       = state;
endmodule

// File: tb/tb_pci_txn_queue.sv
// tb_pci_txn_queue: directed bench for pci_txn_queue (DEPTH=4, TIMEOUT=16).
module tb_pci_txn_queue;
    import pci_txn_queue_pkg::*;

    localparam int DEPTH   = 4;
    localparam int ADDR_W  = 32;
    localparam int CNT_W   = 4;
    localparam int TIMEOUT = 16;
    localparam int LEVEL_W = 3;

    // ---------------- clock / reset ----------------
    logic   clk = 1'b0;
    logic   reset;
    state_t dbg_state;

    always #5 clk = ~clk;

    pci_txn_queue_if #(.ADDR_W(ADDR_W), .CNT_W(CNT_W), .LEVEL_W(LEVEL_W)) bus ();

    pci_txn_queue #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    // ---------------- scoreboard ----------------
    int         n_cmp = 0;
    int         n_bad = 0;
    logic [1:0] exp_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic score_done();
        logic [1:0] e;
        if (exp_q.size() == 0) begin
            check("unexpected_done", 64'(bus.done_status), 64'hdead);
        end else begin
            e = exp_q.pop_front();
            check("done_status", 64'(bus.done_status), 64'(e));
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic idle_inputs();
        bus.cmd_valid = 1'b0;
        bus.cmd_cbe   = 1'b0;
        bus.cmd_addr  = '0;
        bus.cmd_count = '0;
        bus.grant     = 1'b1;
        bus.frame     = 1'b1;
        bus.i_ready   = 1'b1;
        bus.dev_done  = 1'b0;
        bus.dev_abort = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        exp_q.delete();
    endtask

    // Called at a negedge; the push happens on the following posedge.
    task automatic push(input logic cbe, input logic [ADDR_W-1:0] addr, input logic [CNT_W-1:0] cnt);
        bus.cmd_valid = 1'b1;
        bus.cmd_cbe   = cbe;
        bus.cmd_addr  = addr;
        bus.cmd_count = cnt;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic              cbe;
        logic [ADDR_W-1:0] addr;
        logic [CNT_W-1:0]  cnt;
        logic              grant_on;   // grant held low from push onward
        logic              rsp_done;   // pulse dev_done 5 cycles after start
        logic              rsp_abort;  // pulse dev_abort 5 cycles after start
        logic              stray;      // dev_done pulse while still in REQ
        logic [1:0]        status;
        int                starts;
        int                req_low;    // cycles with request==0
    } row_t;

    row_t rows[6];

    task automatic run_row(input int idx, input row_t r);
        int start_k = 0;
        int starts  = 0;
        int dones   = 0;
        int req_low = 0;
        exp_q.push_back(r.status);
        bus.grant   = r.grant_on ? 1'b0 : 1'b1;
        bus.frame   = 1'b1;
        bus.i_ready = 1'b1;
        push(r.cbe, r.addr, r.cnt);
        check($sformatf("row%0d_level_after_push", idx), 64'(bus.level), 64'd1);
        for (int k = 1; k <= 40; k++) begin
            if (!bus.request) req_low++;
            if (bus.dev_start) begin
                starts++;
                if (starts == 1) begin
                    start_k = k;
                    check($sformatf("row%0d_dev_addr", idx), 64'(bus.dev_addr), 64'(r.addr));
                    check($sformatf("row%0d_dev_count", idx), 64'(bus.dev_count), 64'(r.cnt));
                    check($sformatf("row%0d_dev_cbe", idx), 64'(bus.dev_cbe), 64'(r.cbe));
                end
            end
            if (start_k > 0 && k == start_k + 1)
                check($sformatf("row%0d_req_after_start", idx), 64'(bus.request), 64'd1);
            if (bus.done_valid) begin
                dones++;
                score_done();
                check($sformatf("row%0d_addr_held", idx), 64'(bus.dev_addr), 64'(r.addr));
            end
            bus.dev_done  = (r.stray && k == 2) || (r.rsp_done && start_k > 0 && k == start_k + 5);
            bus.dev_abort = r.rsp_abort && start_k > 0 && k == start_k + 5;
            @(negedge clk);
        end
        bus.grant = 1'b1;
        check($sformatf("row%0d_starts", idx), 64'(starts), 64'(r.starts));
        if (r.starts > 0)
            check($sformatf("row%0d_start_latency", idx), 64'(start_k), 64'd4);
        check($sformatf("row%0d_req_low_cycles", idx), 64'(req_low), 64'(r.req_low));
        check($sformatf("row%0d_dones", idx), 64'(dones), 64'd1);
        check($sformatf("row%0d_level_end", idx), 64'(bus.level), 64'd0);
        check($sformatf("row%0d_exp_q_empty", idx), 64'(exp_q.size()), 64'd0);
        exp_q.delete();
    endtask

    // ---------------- test ----------------
    initial begin
        int dones;
        int starts;
        int done_k;
        int done_at;
        int req_low;
        int seen;

        //              cbe   addr          cnt  gnt  done abrt stray status           st req_low
        rows[0] = '{1'b0, 32'h0000_0001, 4'd3,  1'b1, 1'b1, 1'b0, 1'b0, STATUS_OK,      1, 3};
        rows[1] = '{1'b1, 32'h1234_5678, 4'd7,  1'b1, 1'b1, 1'b1, 1'b0, STATUS_ABORT,   1, 3};
        rows[2] = '{1'b1, 32'hdead_beef, 4'd2,  1'b1, 1'b0, 1'b1, 1'b0, STATUS_ABORT,   1, 3};
        rows[3] = '{1'b0, 32'h0000_0055, 4'd5,  1'b0, 1'b0, 1'b0, 1'b1, STATUS_TIMEOUT, 0, 16};
        rows[4] = '{1'b0, 32'h0000_0009, 4'd0,  1'b1, 1'b0, 1'b0, 1'b0, STATUS_ILLEGAL, 0, 0};
        rows[5] = '{1'b1, 32'hffff_ffff, 4'd15, 1'b1, 1'b1, 1'b0, 1'b0, STATUS_OK,      1, 3};

        // Reset values, checked while reset is held and after release.
        idle_inputs();
        reset = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_request",     64'(bus.request),     64'd1);
        check("rst_cmd_ready",   64'(bus.cmd_ready),   64'd1);
        check("rst_level",       64'(bus.level),       64'd0);
        check("rst_dev_start",   64'(bus.dev_start),   64'd0);
        check("rst_done_valid",  64'(bus.done_valid),  64'd0);
        check("rst_done_status", 64'(bus.done_status), 64'd0);
        check("rst_dev_addr",    64'(bus.dev_addr),    64'd0);
        reset = 1'b1;
        @(negedge clk);
        check("post_rst_request", 64'(bus.request), 64'd1);
        check("post_rst_state",   64'(dbg_state),   64'(ST_IDLE));

        for (int i = 0; i < 6; i++) run_row(i, rows[i]);

        // Fill: five pushes with no grant; the fifth is dropped.
        do_reset();
        for (int i = 0; i < 5; i++) begin
            if (i < 4) exp_q.push_back(STATUS_TIMEOUT);
            bus.cmd_valid = 1'b1;
            bus.cmd_cbe   = 1'b0;
            bus.cmd_addr  = 32'(i);
            bus.cmd_count = 4'(i + 1);
            @(negedge clk);
            if (i == 3) begin
                check("fill_cmd_ready_full", 64'(bus.cmd_ready), 64'd0);
                check("fill_level_4",        64'(bus.level),     64'd4);
            end
        end
        bus.cmd_valid = 1'b0;
        check("fill_level_after_5th", 64'(bus.level), 64'd4);
        dones = 0;
        for (int k = 0; k < 120; k++) begin
            if (bus.done_valid) begin
                dones++;
                score_done();
            end
            @(negedge clk);
        end
        check("fill_dones", 64'(dones), 64'd4);
        check("fill_level_end", 64'(bus.level), 64'd0);
        check("fill_cmd_ready_end", 64'(bus.cmd_ready), 64'd1);

        // Back-to-back: request must be high in RETIRE and the IDLE after it.
        do_reset();
        bus.grant = 1'b0;
        exp_q.push_back(STATUS_OK);
        exp_q.push_back(STATUS_OK);
        bus.cmd_valid = 1'b1;
        bus.cmd_addr  = 32'h100;
        bus.cmd_count = 4'd2;
        @(negedge clk);
        bus.cmd_addr  = 32'h200;
        bus.cmd_count = 4'd3;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        dones = 0; starts = 0; done_k = -10; done_at = -1;
        for (int k = 0; k < 60; k++) begin
            if (bus.dev_start) begin
                starts++;
                done_at = k + 3;
                check($sformatf("b2b_addr%0d", starts), 64'(bus.dev_addr), 64'(starts * 256));
            end
            if (bus.done_valid) begin
                dones++;
                score_done();
                if (dones == 1) begin
                    done_k = k;
                    check("b2b_req_retire", 64'(bus.request), 64'd1);
                end
            end
            if (k == done_k + 1) check("b2b_req_idle", 64'(bus.request), 64'd1);
            bus.dev_done = (k == done_at);
            @(negedge clk);
        end
        bus.dev_done = 1'b0;
        check("b2b_starts", 64'(starts), 64'd2);
        check("b2b_dones",  64'(dones),  64'd2);

        // Reset during BUSY: outputs inactive at once, nothing reported later.
        do_reset();
        bus.grant = 1'b0;
        push(1'b1, 32'hcafe_0000, 4'd4);
        seen = 0;
        for (int k = 0; k < 20 && seen == 0; k++) begin
            if (bus.dev_start) seen = 1;
            @(negedge clk);
        end
        check("mid_start_seen", 64'(seen), 64'd1);
        check("mid_in_busy", 64'(dbg_state), 64'(ST_BUSY));
        #2 reset = 1'b0;
        #1;
        check("mid_rst_request",   64'(bus.request),   64'd1);
        check("mid_rst_level",     64'(bus.level),     64'd0);
        check("mid_rst_dev_start", 64'(bus.dev_start), 64'd0);
        check("mid_rst_state",     64'(dbg_state),     64'(ST_IDLE));
        @(negedge clk);
        reset = 1'b1;
        dones = 0; req_low = 0;
        for (int k = 0; k < 20; k++) begin
            if (bus.done_valid) dones++;
            if (!bus.request) req_low++;
            bus.dev_done = (k == 2);
            @(negedge clk);
        end
        bus.dev_done = 1'b0;
        check("mid_no_done",  64'(dones),   64'd0);
        check("mid_req_high", 64'(req_low), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Global watchdog.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "watchdog expired");
    end
endmodule
